// File: rtl/qed_feed_sched_if.sv
// Fetch-side bundle of the QED feed scheduler: DUT fetch port, workload FIFO
// port, QED generator port and scheduler status.
interface qed_feed_sched_if;
  logic        inst_fifo_rd;
  logic [31:0] inst_fifo_rdata;
  logic        wl_empty;
  logic        wl_rd;
  logic [31:0] wl_rdata;
  logic        qed_rd;
  logic [31:0] qed_rdata;
  logic        qed_ena;
  logic [1:0]  sched_state;
  logic [15:0] nop_cnt;

  modport master (
    input  inst_fifo_rd, wl_empty, wl_rdata, qed_rdata,
    output inst_fifo_rdata, wl_rd, qed_rd, qed_ena, sched_state, nop_cnt
  );

  modport slave (
    output inst_fifo_rd, wl_empty, wl_rdata, qed_rdata,
    input  inst_fifo_rdata, wl_rd, qed_rd, qed_ena, sched_state, nop_cnt
  );
endinterface

// File: rtl/qed_feed_sched.sv
// Instruction feed scheduler: workload during WARMUP, NOP filler in DRAIN,
// then QED generator words forever; fetch path is purely combinational.
module qed_feed_sched #(
  parameter int unsigned WARMUP_CYCLES = 63,
  parameter int unsigned DRAIN_NOPS    = 8,
  parameter logic [31:0] NOP_INST      = 32'h00000013
) (
  input  logic             clock,
  input  logic             reset_n,
  qed_feed_sched_if.master bus
);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    DRAIN  = 2'd1,
    QED    = 2'd2
  } state_t;

  localparam logic [15:0] WARMUP_LAST = 16'(WARMUP_CYCLES - 1);
  localparam logic [7:0]  DRAIN_LAST  = 8'(DRAIN_NOPS - 1);
  localparam state_t      AFTER_WARMUP = (DRAIN_NOPS == 0) ? QED : DRAIN;

  state_t      state_reg, state_next;
  logic [15:0] cyc_cnt_reg, cyc_cnt_next;
  logic [7:0]  drain_cnt_reg, drain_cnt_next;
  logic [15:0] nop_cnt_reg, nop_cnt_next;

  logic        wl_rd_c;
  logic        qed_rd_c;
  logic [31:0] rdata_c;
  logic        filler_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= WARMUP;
      cyc_cnt_reg   <= 16'd0;
      drain_cnt_reg <= 8'd0;
      nop_cnt_reg   <= 16'd0;
    end else begin
      state_reg     <= state_next;
      cyc_cnt_reg   <= cyc_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      nop_cnt_reg   <= nop_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cyc_cnt_next   = cyc_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    wl_rd_c        = 1'b0;
    qed_rd_c       = 1'b0;
    rdata_c        = NOP_INST;
    filler_c       = 1'b0;

    case (state_reg)
      WARMUP: begin
        cyc_cnt_next = cyc_cnt_reg + 16'd1;
        wl_rd_c      = bus.inst_fifo_rd & ~bus.wl_empty;
        rdata_c      = wl_rd_c ? bus.wl_rdata : NOP_INST;
        filler_c     = bus.inst_fifo_rd & bus.wl_empty;
        if (cyc_cnt_reg == WARMUP_LAST) begin
          state_next = AFTER_WARMUP;
        end
      end
      DRAIN: begin
        filler_c = bus.inst_fifo_rd;
        if (bus.inst_fifo_rd) begin
          drain_cnt_next = drain_cnt_reg + 8'd1;
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_next = QED;
          end
        end
      end
      QED: begin
        qed_rd_c = bus.inst_fifo_rd;
        rdata_c  = bus.qed_rdata;
      end
      default: begin
        state_next = WARMUP;
      end
    endcase

    // The state register already sits in WARMUP under reset, but WARMUP still
    // forwards fetches, so the strobes must be gated by reset_n directly.
    if (!reset_n) begin
      wl_rd_c  = 1'b0;
      qed_rd_c = 1'b0;
      rdata_c  = NOP_INST;
      filler_c = 1'b0;
    end

    nop_cnt_next = (filler_c && (nop_cnt_reg != 16'hFFFF)) ? nop_cnt_reg + 16'd1 : nop_cnt_reg;
  end

  assign bus.inst_fifo_rdata = rdata_c;
  assign bus.wl_rd           = wl_rd_c;
  assign bus.qed_rd          = qed_rd_c;
  assign bus.qed_ena         = (state_reg == QED);
  assign bus.sched_state     = state_reg;
  assign bus.nop_cnt         = nop_cnt_reg;

endmodule

// File: tb/tb_qed_feed_sched.sv
// Directed bench for qed_feed_sched: default instance plus a 4-cycle WARMUP,
// zero-drain instance driven by the same stimulus.
module tb_qed_feed_sched;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] WL  = 32'h00500093;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd = 1'b0;
  logic        empty = 1'b0;
  logic [31:0] wdata = WL;
  logic [31:0] qdata = 32'hC0DE0000;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  qed_feed_sched_if bus_a ();
  qed_feed_sched_if bus_b ();

  assign bus_a.inst_fifo_rd = rd;
  assign bus_a.wl_empty     = empty;
  assign bus_a.wl_rdata     = wdata;
  assign bus_a.qed_rdata    = qdata;
  assign bus_b.inst_fifo_rd = rd;
  assign bus_b.wl_empty     = empty;
  assign bus_b.wl_rdata     = wdata;
  assign bus_b.qed_rdata    = qdata;

  qed_feed_sched dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
  qed_feed_sched #(.WARMUP_CYCLES(4), .DRAIN_NOPS(0)) dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Invariants sampled every cycle on both instances.
  logic [15:0] prev_a = 16'd0;
  logic [15:0] prev_b = 16'd0;
  always @(negedge reset_n) begin
    prev_a = 16'd0;
    prev_b = 16'd0;
  end
  always @(negedge clock) begin
    if (reset_n) begin
      chk("inv_a_excl", {31'd0, bus_a.wl_rd & bus_a.qed_rd}, 32'd0);
      chk("inv_b_excl", {31'd0, bus_b.wl_rd & bus_b.qed_rd}, 32'd0);
      chk("inv_a_idle", {31'd0, ~rd & (bus_a.wl_rd | bus_a.qed_rd)}, 32'd0);
      chk("inv_a_ena", {31'd0, bus_a.qed_ena}, {31'd0, bus_a.sched_state == 2'd2});
      chk("inv_b_ena", {31'd0, bus_b.qed_ena}, {31'd0, bus_b.sched_state == 2'd2});
      chk("inv_a_mono", {31'd0, bus_a.nop_cnt >= prev_a}, 32'd1);
      chk("inv_b_mono", {31'd0, bus_b.nop_cnt >= prev_b}, 32'd1);
      prev_a = bus_a.nop_cnt;
      prev_b = bus_b.nop_cnt;
    end else begin
      prev_a = 16'd0;
      prev_b = 16'd0;
    end
  end

  // Reset spanning one full clock; cycle 0 starts 1 time unit after a rising edge.
  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  initial begin
    // Scenario 1: workload always available, fetch every cycle.
    rd = 1'b1; empty = 1'b0;
    #2;
    chk("rst_rdata", bus_a.inst_fifo_rdata, NOP);
    chk("rst_wl_rd", {31'd0, bus_a.wl_rd}, 32'd0);
    chk("rst_qed_rd", {31'd0, bus_a.qed_rd}, 32'd0);
    chk("rst_state", {30'd0, bus_a.sched_state}, 32'd0);
    chk("rst_ena", {31'd0, bus_a.qed_ena}, 32'd0);
    chk("rst_nop", {16'd0, bus_a.nop_cnt}, 32'd0);
    chk("rst_b_wl_rd", {31'd0, bus_b.wl_rd}, 32'd0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      qdata = 32'hC0DE0000 | 32'(k);
      @(negedge clock);
      chk("s1_a_rdata", bus_a.inst_fifo_rdata, (k < 63) ? WL : (k < 71) ? NOP : qdata);
      chk("s1_a_state", {30'd0, bus_a.sched_state}, (k < 63) ? 32'd0 : (k < 71) ? 32'd1 : 32'd2);
      chk("s1_a_wl_rd", {31'd0, bus_a.wl_rd}, (k < 63) ? 32'd1 : 32'd0);
      chk("s1_a_qed_rd", {31'd0, bus_a.qed_rd}, (k >= 71) ? 32'd1 : 32'd0);
      chk("s1_b_rdata", bus_b.inst_fifo_rdata, (k < 4) ? WL : qdata);
      chk("s1_b_state", {30'd0, bus_b.sched_state}, (k < 4) ? 32'd0 : 32'd2);
      chk("s1_b_qed_rd", {31'd0, bus_b.qed_rd}, (k >= 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("s1_a_nop", {16'd0, bus_a.nop_cnt}, 32'd8);
    chk("s1_b_nop", {16'd0, bus_b.nop_cnt}, 32'd0);
    $display("scenario 1 done: a.nop_cnt=%0d b.nop_cnt=%0d", bus_a.nop_cnt, bus_b.nop_cnt);

    // Scenario 2: workload FIFO empty throughout.
    empty = 1'b1;
    do_reset();
    for (int k = 0; k < 75; k++) begin
      qdata = 32'hBEEF0000 | 32'(k);
      @(negedge clock);
      chk("s2_a_rdata", bus_a.inst_fifo_rdata, (k < 71) ? NOP : qdata);
      chk("s2_a_wl_rd", {31'd0, bus_a.wl_rd}, 32'd0);
      chk("s2_a_nop", {16'd0, bus_a.nop_cnt}, (k < 71) ? 32'(k) : 32'd71);
      chk("s2_b_nop", {16'd0, bus_b.nop_cnt}, (k < 4) ? 32'(k) : 32'd4);
      step();
    end
    $display("scenario 2 done: a.nop_cnt=%0d b.nop_cnt=%0d", bus_a.nop_cnt, bus_b.nop_cnt);

    // Scenario 3: fetch stalls for 20 cycles at the start of DRAIN.
    empty = 1'b0;
    do_reset();
    for (int k = 0; k < 63; k++) step();
    rd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("s3_stall_state", {30'd0, bus_a.sched_state}, 32'd1);
      chk("s3_stall_ena", {31'd0, bus_a.qed_ena}, 32'd0);
      chk("s3_stall_wl_rd", {31'd0, bus_a.wl_rd}, 32'd0);
      step();
    end
    chk("s3_nop_stall", {16'd0, bus_a.nop_cnt}, 32'd0);
    rd = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      chk("s3_drain_ena", {31'd0, bus_a.qed_ena}, 32'd0);
      chk("s3_drain_rdata", bus_a.inst_fifo_rdata, NOP);
      step();
    end
    @(negedge clock);
    chk("s3_qed_ena", {31'd0, bus_a.qed_ena}, 32'd1);
    chk("s3_qed_rdata", bus_a.inst_fifo_rdata, qdata);
    chk("s3_nop", {16'd0, bus_a.nop_cnt}, 32'd8);
    $display("scenario 3 done: a.state=%0d a.nop_cnt=%0d", bus_a.sched_state, bus_a.nop_cnt);

    // Scenario 4: asynchronous reset after 3 DRAIN NOPs.
    do_reset();
    for (int k = 0; k < 66; k++) step();
    @(negedge clock);
    chk("s4_pre_state", {30'd0, bus_a.sched_state}, 32'd1);
    chk("s4_pre_nop", {16'd0, bus_a.nop_cnt}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s4_async_state", {30'd0, bus_a.sched_state}, 32'd0);
    chk("s4_async_nop", {16'd0, bus_a.nop_cnt}, 32'd0);
    chk("s4_async_rdata", bus_a.inst_fifo_rdata, NOP);
    chk("s4_async_wl_rd", {31'd0, bus_a.wl_rd}, 32'd0);
    chk("s4_async_b_qed_rd", {31'd0, bus_b.qed_rd}, 32'd0);
    chk("s4_async_b_ena", {31'd0, bus_b.qed_ena}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      chk("s4_state", {30'd0, bus_a.sched_state}, (k < 63) ? 32'd0 : 32'd1);
      chk("s4_rdata", bus_a.inst_fifo_rdata, (k < 63) ? WL : NOP);
      chk("s4_nop", {16'd0, bus_a.nop_cnt}, 32'd0);
      step();
    end
    $display("scenario 4 done: a.state=%0d a.nop_cnt=%0d", bus_a.sched_state, bus_a.nop_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
